// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiply / restoring divide unit sharing one datapath and FSM.
// Define MULTDIV_ITER_EARLY_OUT_EN to finish divide-by-zero and multiply-by-zero in one cycle.
module multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]    acc_q, acc_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  a_q;
  logic              op_div_q, signed_q, neg_res_q, neg_a_q, b_zero_q, ovf_q;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic              exc_q, exc_d;

  logic              start, start_div, early;
  logic              neg_a_in, neg_b_in;
  logic [WIDTH-1:0]  mag_a_in, mag_b_in;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ~ctrl_MULT & ctrl_DIV;
  assign neg_a_in  = ctrl_signed & data_operandA[WIDTH-1];
  assign neg_b_in  = ctrl_signed & data_operandB[WIDTH-1];
  assign mag_a_in  = neg_a_in ? -data_operandA : data_operandA;
  assign mag_b_in  = neg_b_in ? -data_operandB : data_operandB;

`ifdef MULTDIV_ITER_EARLY_OUT_EN
  assign early = start & (start_div ? (data_operandB == '0)
                                    : ((data_operandA == '0) | (data_operandB == '0)));
`else
  assign early = 1'b0;
`endif

  // One radix-2 step for each operation.
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;

  assign mul_sum  = acc_q + {1'b0, (lo_q[0] ? mcand_q : '0)};
  assign rem_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, mcand_q};
  assign div_ge   = ~div_diff[WIDTH+1];

  // Sign correction and exception evaluated while in FIX.
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic               fix_exc;

  assign prod_mag = {acc_q[WIDTH-1:0], lo_q};
  assign prod     = neg_res_q ? -prod_mag : prod_mag;
  assign quo      = neg_res_q ? -lo_q : lo_q;
  assign rem      = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    fix_lo  = prod[WIDTH-1:0];
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_exc = signed_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                       : (prod[2*WIDTH-1:WIDTH] != '0);
    if (op_div_q) begin
      if (b_zero_q) begin
        fix_lo  = '0;
        fix_hi  = a_q;
        fix_exc = 1'b1;
      end else begin
        fix_lo  = quo;
        fix_hi  = rem;
        fix_exc = ovf_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    exc_d    = exc_q;
    if (start) begin
      // A start in any state (re)launches; whatever was in flight is dropped.
      state_d = early ? StDone : StCalc;
      cnt_d   = '0;
      acc_d   = '0;
      lo_d    = start_div ? mag_a_in : mag_b_in;
      mcand_d = start_div ? mag_b_in : mag_a_in;
      if (early) begin
        res_lo_d = '0;
        res_hi_d = start_div ? data_operandA : '0;
        exc_d    = start_div;
      end
    end else begin
      unique case (state_q)
        StCalc: begin
          cnt_d = cnt_q + CntW'(1);
          if (op_div_q) begin
            acc_d = div_ge ? div_diff[WIDTH:0] : rem_sh;
            lo_d  = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
        StFix: begin
          state_d  = StDone;
          res_lo_d = fix_lo;
          res_hi_d = fix_hi;
          exc_d    = fix_exc;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      res_lo_q <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      exc_q    <= exc_d;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q   <= cnt_d;
    acc_q   <= acc_d;
    lo_q    <= lo_d;
    mcand_q <= mcand_d;
    if (start) begin
      a_q       <= data_operandA;
      op_div_q  <= start_div;
      signed_q  <= ctrl_signed;
      neg_res_q <= neg_a_in ^ neg_b_in;
      neg_a_q   <= neg_a_in;
      b_zero_q  <= (data_operandB == '0);
      ovf_q     <= ctrl_signed & (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                   & (data_operandB == '1);
    end
  end

  assign data_result    = res_lo_q;
  assign data_result_hi = res_hi_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q != StIdle);

endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Parametrised iterative integer multiply/divide unit for the processor's execute stage.
- One shared datapath and FSM do both operations. Operand width is configurable, and signed or unsigned mode is chosen per operation.
- Returns the full double-width product (hi:lo), or the quotient and remainder.
- Reports exceptions for overflow and divide-by-zero.
- Uses a start-pulse / ready-pulse handshake with a busy flag.

Parameters:
- WIDTH, 32: operand and result width in bits; legal values are 4 to 64.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- data_operandA  input  WIDTH  multiplicand or dividend; sampled only in the start cycle
- data_operandB  input  WIDTH  multiplier or divisor; sampled only in the start cycle
- ctrl_MULT  input  1  single-cycle start pulse for multiply
- ctrl_DIV  input  1  single-cycle start pulse for divide
- ctrl_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with the start pulse
- data_result  output  WIDTH  product low half, or quotient
- data_result_hi  output  WIDTH  product high half, or remainder
- data_exception  output  1  exception flag; valid when data_resultRDY=1 and held until the next start
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (reset_n=0 at a rising edge): FSM goes to IDLE.
  - data_result, data_result_hi, data_exception, data_resultRDY and busy all read 0.
  - Reset overrides any operation in flight; that operation is lost and produces no RDY pulse.
- Start cycle: any cycle in which ctrl_MULT or ctrl_DIV is 1.
  - Operands, ctrl_signed and the operation type are latched.
  - If both controls are high in the same cycle, MULT wins.
- FSM states:
  - IDLE -> CALC on start.
  - CALC runs exactly WIDTH cycles, one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. It operates on operand magnitudes when signed.
  - CALC -> FIX: one cycle. Applies the sign correction and computes the exception.
  - FIX -> DONE: one cycle. data_resultRDY=1 and results are driven.
  - DONE -> IDLE.
- Latency: data_resultRDY rises exactly WIDTH+2 cycles after the start cycle (34 for WIDTH=32).
- busy: high from the cycle after start through DONE inclusive.
- Output hold: data_result, data_result_hi and data_exception update only on entry to DONE. They hold through IDLE until the next DONE.
- Restart: a start while busy aborts the current operation and restarts with the new operands and mode.
  - The aborted operation produces no RDY pulse.
  - The latency count restarts from the new start cycle.
- Multiply result: {data_result_hi, data_result} is the exact 2*WIDTH-bit product (signed or unsigned).
  - data_exception=1 when the product does not fit in WIDTH bits.
  - Signed: hi is not the sign-extension of lo[WIDTH-1].
  - Unsigned: hi != 0.
- Divide result: quotient truncates toward zero; remainder takes the sign of the dividend. A = Q*B + R always holds except for divide-by-zero.
- Divide-by-zero (B=0): quotient = 0, remainder = A, data_exception=1. Standard latency applies unless the optional feature is enabled.
- Signed MIN / -1: quotient = MIN (2^(WIDTH-1)), remainder = 0, data_exception=1.
- No internal state persists between operations. Internal registers need not be cleared in IDLE.

Optional Feature:
- Macro: MULTDIV_ITER_EARLY_OUT_EN
- Defined:
  - Divide-by-zero skips CALC and FIX. The FSM goes from the start cycle straight to DONE, so data_resultRDY rises 1 cycle after start.
  - Multiply by operand 0 does the same, returning 0:0 with exception 0.
  - All other operations keep WIDTH+2 latency.
- Undefined: every operation takes WIDTH+2 cycles; no early exit.

Test Plan:
- Signed multiply, WIDTH=32, A=7, B=-6 (0xFFFFFFFA) -> after 34 cycles RDY pulses once with lo=0xFFFFFFD6, hi=0xFFFFFFFF, exc=0.
- Unsigned multiply, A=0x00010000, B=0x00010000 -> lo=0x00000000, hi=0x00000001, exc=1. The same operands in signed mode give the same results and exc=1.
- Signed divide, A=-7, B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), exc=0. Unsigned divide, A=0xFFFFFFFF, B=2 -> Q=0x7FFFFFFF, R=1, exc=0.
- Divide-by-zero, A=123, B=0 -> Q=0, R=123, exc=1; RDY at 34 cycles, or at 1 cycle with MULTDIV_ITER_EARLY_OUT_EN. Signed 0x80000000 / -1 -> Q=0x80000000, R=0, exc=1.
- Restart: start a multiply of 3*5, then start a divide of 100/7 ten cycles later -> exactly one RDY pulse, 34 cycles after the divide start, with Q=14, R=2. No pulse for the multiply.
- Reset mid-operation: start a multiply, drive reset_n=0 for one cycle at cycle 5 -> all outputs read 0 and busy=0 the cycle after. No RDY ever appears. A following 2*3 gives lo=6 at the nominal latency.
